// File: rtl/pipeline_pkg.sv
// Shared constants and event layout for the strip-data L0 readout path.
// An event is {L0ID, BCID, strip data}; the circular buffer stores {BCID, data}.
package pipeline_pkg;

  localparam int WIDTH  = 256;
  localparam int DEPTH  = 256;
  localparam int AW     = $clog2(DEPTH);
  localparam int FDEPTH = 8;

  localparam int ID_W   = 8;
  localparam int META_W = 2 * ID_W;

  typedef struct packed {
    logic [ID_W-1:0]  l0id;
    logic [ID_W-1:0]  bcid;
    logic [WIDTH-1:0] data;
  } event_t;

endpackage

// File: rtl/derand_fifo.sv
// First-word-fall-through derandomizer FIFO. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module derand_fifo #(
  parameter int DW     = 272,
  parameter int FDEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          valid,
  output logic          full
);

  localparam int PW = $clog2(FDEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem [FDEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;
  logic          empty;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(FDEPTH));
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head is forced to zero when empty so reset shows clean outputs.
  assign valid = !empty;
  assign dout  = empty ? '0 : mem[rd_ptr_q];

endmodule

// File: rtl/pipeline_readout.sv
// Circular L0 pipeline buffer: writes {BCID, pipeLine} every BC, reads the
// entry `latency` BCs back on L0, tags it with an L0ID and queues it.
module pipeline_readout #(
  parameter int WIDTH  = pipeline_pkg::WIDTH,
  parameter int DEPTH  = pipeline_pkg::DEPTH,
  parameter int FDEPTH = pipeline_pkg::FDEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             BCclk,
  input  logic             hrdrst,
  input  logic [WIDTH-1:0] pipeLine,
  input  logic [7:0]       BCID,
  input  logic [AW-1:0]    latency,
  input  logic             L0,
  output logic [WIDTH-1:0] readData,
  output logic [7:0]       readBCID,
  output logic [7:0]       readL0ID,
  output logic             readValid,
  input  logic             readReady,
  output logic             fifoFull,
  output logic             overflow,
  output logic [7:0]       dropCount
);

  import pipeline_pkg::*;

  localparam int RW = WIDTH + ID_W;
  localparam int EW = WIDTH + META_W;

  logic [RW-1:0]   ram [DEPTH];
  logic [RW-1:0]   rd_word_q;

  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   raddr;
  logic [ID_W-1:0] l0id_q, l0id_d;
  logic            pend_q, pend_d;
  logic [ID_W-1:0] pend_l0id_q, pend_l0id_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  logic            pop, drop;
  logic            fifo_valid, fifo_full;
  logic [EW-1:0]   fifo_din, fifo_dout;

  // Natural AW-bit wrap gives the modulo-DEPTH lookback.
  assign raddr = wptr_q - latency;

  // RAM and its read register are deliberately not reset.
  always_ff @(posedge BCclk) begin
    ram[wptr_q] <= {BCID, pipeLine};
    if (L0) rd_word_q <= ram[raddr];
  end

  always_comb begin
    pop         = fifo_valid && readReady;
    drop        = pend_q && fifo_full && !pop;
    wptr_d      = wptr_q + AW'(1);
    pend_d      = L0;
    pend_l0id_d = L0 ? l0id_q : pend_l0id_q;
    l0id_d      = L0 ? l0id_q + ID_W'(1) : l0id_q;
    overflow_d  = overflow_q || drop;
    drop_cnt_d  = drop_cnt_q;
    if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    fifo_din    = {pend_l0id_q, rd_word_q};
  end

  always_ff @(posedge BCclk or posedge hrdrst) begin
    if (hrdrst) begin
      wptr_q      <= '0;
      l0id_q      <= '0;
      pend_q      <= 1'b0;
      pend_l0id_q <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      l0id_q      <= l0id_d;
      pend_q      <= pend_d;
      pend_l0id_q <= pend_l0id_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  derand_fifo #(
    .DW     (EW),
    .FDEPTH (FDEPTH)
  ) u_derand (
    .clk   (BCclk),
    .rst   (hrdrst),
    .push  (pend_q),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .full  (fifo_full)
  );

  assign readData  = fifo_dout[WIDTH-1:0];
  assign readBCID  = fifo_dout[WIDTH +: ID_W];
  assign readL0ID  = fifo_dout[RW +: ID_W];
  assign readValid = fifo_valid;
  assign fifoFull  = fifo_full;
  assign overflow  = overflow_q;
  assign dropCount = drop_cnt_q;

endmodule

// File: tb/tb_pipeline_readout.sv
// Scoreboard bench for pipeline_readout: stimulus pushes expected events,
// a negedge monitor pops and compares on every readValid & readReady.
module tb_pipeline_readout;

  logic         BCclk;
  logic         hrdrst;
  logic [255:0] pipeLine;
  logic [7:0]   BCID;
  logic [7:0]   latency;
  logic         L0;
  logic [255:0] readData;
  logic [7:0]   readBCID;
  logic [7:0]   readL0ID;
  logic         readValid;
  logic         readReady;
  logic         fifoFull;
  logic         overflow;
  logic [7:0]   dropCount;

  typedef struct {
    logic [7:0]   l0id;
    logic [7:0]   bcid;
    logic [255:0] data;
  } exp_t;

  exp_t       sbq[$];
  exp_t       mon_e;
  int         errors = 0;
  int         checks = 0;
  int         bc = 0;
  logic [7:0] l0id_m = 8'd0;

  pipeline_readout #(
    .WIDTH  (256),
    .DEPTH  (256),
    .FDEPTH (8)
  ) dut (
    .BCclk     (BCclk),
    .hrdrst    (hrdrst),
    .pipeLine  (pipeLine),
    .BCID      (BCID),
    .latency   (latency),
    .L0        (L0),
    .readData  (readData),
    .readBCID  (readBCID),
    .readL0ID  (readL0ID),
    .readValid (readValid),
    .readReady (readReady),
    .fifoFull  (fifoFull),
    .overflow  (overflow),
    .dropCount (dropCount)
  );

  initial BCclk = 1'b0;
  always #5 BCclk = ~BCclk;

  function automatic logic [255:0] pat(input int n);
    logic [255:0] p;
    logic [31:0]  nv;
    nv = 32'(n);
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = nv ^ (32'(i) << 28);
    return p;
  endfunction

  task automatic tick();
    @(posedge BCclk);
    #1;
    bc++;
    pipeLine = pat(bc);
    BCID     = bc[7:0];
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Drives L0 for the next edge; the sampled word is the one written lat_v BCs earlier.
  task automatic fire(input int lat_v, input bit accept);
    exp_t e;
    L0 = 1'b1;
    if (accept) begin
      e.l0id = l0id_m;
      e.bcid = 8'(bc - lat_v);
      e.data = pat(bc - lat_v);
      sbq.push_back(e);
    end
    l0id_m = l0id_m + 8'd1;
    tick();
  endtask

  initial begin
    forever begin
      @(negedge BCclk);
      if (hrdrst === 1'b0 && readValid === 1'b1 && readReady === 1'b1) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pop: got l0id=%0h bcid=%0h expected no event", readL0ID, readBCID);
        end else begin
          mon_e = sbq.pop_front();
          if ({readL0ID, readBCID, readData} !== {mon_e.l0id, mon_e.bcid, mon_e.data}) begin
            errors++;
            $display("FAIL pop: got l0id=%0h bcid=%0h data=%0h expected l0id=%0h bcid=%0h data=%0h",
                     readL0ID, readBCID, readData[63:0], mon_e.l0id, mon_e.bcid, mon_e.data[63:0]);
          end else begin
            $display("ok   pop l0id=%0h bcid=%0h data=%0h", readL0ID, readBCID, readData[63:0]);
          end
        end
      end
    end
  end

  initial begin
    hrdrst    = 1'b1;
    L0        = 1'b0;
    readReady = 1'b0;
    latency   = 8'd10;
    pipeLine  = pat(0);
    BCID      = 8'd0;
    repeat (3) tick();
    check("rst_valid",    64'(readValid), 64'd0);
    check("rst_full",     64'(fifoFull),  64'd0);
    check("rst_overflow", 64'(overflow),  64'd0);
    check("rst_dropcnt",  64'(dropCount), 64'd0);
    check("rst_data",     readData[63:0], 64'd0);
    check("rst_bcid",     64'(readBCID),  64'd0);
    check("rst_l0id",     64'(readL0ID),  64'd0);
    hrdrst = 1'b0;

    // Basic latency
    readReady = 1'b1;
    while (bc < 300) tick();
    fire(10, 1'b1);
    L0 = 1'b0;
    check("lat_valid_1bc", 64'(readValid), 64'd0);
    tick();
    check("lat_valid_2bc", 64'(readValid), 64'd1);
    check("lat_l0id",      64'(readL0ID),  64'd0);
    repeat (3) tick();

    // Wrap of the write pointer underneath the lookback
    latency = 8'd200;
    while (bc < 516) tick();
    fire(200, 1'b1);
    L0 = 1'b0;
    tick();
    check("wrap_bcid", 64'(readBCID), 64'd60);
    repeat (3) tick();
    check("wrap_drained", 64'(readValid), 64'd0);

    // Back-to-back fill, then overflow
    latency   = 8'd10;
    readReady = 1'b0;
    for (int i = 0; i < 8; i++) fire(10, 1'b1);
    fire(10, 1'b0);
    L0 = 1'b0;
    check("b2b_full",        64'(fifoFull), 64'd1);
    check("b2b_no_overflow", 64'(overflow), 64'd0);
    tick();
    check("ovf_flag",    64'(overflow),  64'd1);
    check("ovf_dropcnt", 64'(dropCount), 64'd1);

    // Push and pop in the same cycle while full
    fire(10, 1'b1);
    L0        = 1'b0;
    readReady = 1'b1;
    tick();
    readReady = 1'b0;
    check("fullpop_full",    64'(fifoFull),  64'd1);
    check("fullpop_dropcnt", 64'(dropCount), 64'd1);
    readReady = 1'b1;
    repeat (12) tick();
    check("drain_queue", 64'(sbq.size()), 64'd0);
    check("drain_valid", 64'(readValid),  64'd0);

    // Reset with three queued and one in flight
    readReady = 1'b0;
    for (int i = 0; i < 4; i++) fire(10, 1'b1);
    L0     = 1'b0;
    hrdrst = 1'b1;
    #1;
    check("mrst_valid",    64'(readValid), 64'd0);
    check("mrst_full",     64'(fifoFull),  64'd0);
    check("mrst_overflow", 64'(overflow),  64'd0);
    check("mrst_dropcnt",  64'(dropCount), 64'd0);
    check("mrst_data",     readData[63:0], 64'd0);
    check("mrst_l0id",     64'(readL0ID),  64'd0);
    sbq.delete();
    l0id_m = 8'd0;
    repeat (2) tick();
    hrdrst = 1'b0;
    repeat (3) tick();
    check("mrst_no_inflight", 64'(readValid), 64'd0);
    repeat (20) tick();
    readReady = 1'b1;
    fire(10, 1'b1);
    L0 = 1'b0;
    tick();
    check("post_rst_valid", 64'(readValid), 64'd1);
    check("post_rst_l0id",  64'(readL0ID),  64'd0);
    repeat (4) tick();
    check("final_queue", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipeline_readout.md
# pipeline_readout

Read side of the strip-data L0 pipeline. Each BC the block writes the masked `pipeLine` word from `pipeLineEntry` and its BCID into a circular buffer. On an L0 accept it retrieves the entry written `latency` BCs earlier. It tags that entry with an L0ID and queues it in a small derandomizer FIFO, which the downstream cluster finder drains over a valid/ready handshake.

## Interface
- `WIDTH`, 256: pipeline word width (256 or 264).
- `DEPTH`, 256: circular buffer entries; power of two; `AW = log2(DEPTH)`.
- `FDEPTH`, 8: derandomizer entries; power of two.
- `BCclk` input 1: bunch-crossing clock; all logic on its rising edge.
- `hrdrst` input 1: asynchronous, active-high reset.
- `pipeLine` input WIDTH: masked strip word from `pipeLineEntry`, written every BC.
- `BCID` input 8: BC counter value accompanying `pipeLine`.
- `latency` input AW: L0 latency in BCs; quasi-static, changed only while `L0` is low.
- `L0` input 1: L0 accept, one BC wide; back-to-back allowed.
- `readData` output WIDTH: head-of-FIFO strip word.
- `readBCID` output 8: BCID stored with that word.
- `readL0ID` output 8: L0ID assigned to that event.
- `readValid` output 1: head entry valid.
- `readReady` input 1: consumer accepts the head when `readValid & readReady`.
- `fifoFull` output 1: derandomizer holds FDEPTH entries.
- `overflow` output 1: sticky; set when an event is dropped.
- `dropCount` output 8: number of dropped events; saturates at 255.

## Operation
- Write pointer `wptr` (AW bits) increments every BC and wraps DEPTH-1→0. Each BC, `{BCID, pipeLine}` is written at `wptr`.
- When `L0` is sampled high, read address `raddr = (wptr - latency) mod DEPTH`, computed in AW-bit unsigned arithmetic with natural wrap.
- Read-during-write at the same address (`latency` = 0) returns the old contents, i.e. the word written DEPTH BCs earlier. This is legal but not a supported operating point.
- L0ID counter (8 bits, wraps 255→0) increments on every L0, dropped or not. Each event carries the pre-increment value, so the first L0 after reset is tagged 0.
- The retrieved word is registered for one BC, then pushed into the FIFO.
- A push when `fifoFull` is low, or when `fifoFull` is high and a pop happens the same cycle, is accepted.
- Otherwise the event is dropped: `overflow` sets, `dropCount` increments (saturating), and the L0ID is still consumed.
- The FIFO is first-word fall-through. Outputs are held stable while `readValid & ~readReady`.
- Buffer RAM is not reset. Events read before DEPTH BCs have elapsed since reset carry undefined strip data, though their BCID and L0ID fields are defined.

## Timing
- Reset values: `wptr`=0, L0ID=0, FIFO empty, `readValid`=0, `fifoFull`=0, `overflow`=0, `dropCount`=0.
- While reset is asserted, `readData` and `readBCID` are 0 and `readL0ID`=0.
- With L0 sampled at edge k, the RAM is read at edge k, the FIFO is pushed at edge k+1, and `readValid` is high after edge k+1 if the FIFO was empty. L0-to-valid latency is 2 BCs.
- The returned word is the one written at edge k−`latency`.
- Sustained throughput: one L0 per BC in and one pop per BC out.
- Simultaneous push and pop on an empty FIFO: the push wins and `readValid` rises.
- Reset asserted mid-operation aborts any in-flight event (never pushed) and empties the FIFO immediately.

## Structure
- Shared package `pipeline_pkg`: WIDTH, DEPTH, AW, default FDEPTH, and the event word layout `{L0ID[7:0], BCID[7:0], data[WIDTH-1:0]}`.
- Sub-module `derand_fifo`: parameterised FWFT FIFO with count, full, and push/pop-same-cycle support. The top level holds the circular buffer, pointers, L0ID and drop logic.

## Test plan
- **Basic latency:** `latency`=10, `pipeLine` = BC index pattern, single L0 at BC 300 → after 2 BCs `readValid`=1, `readData` = pattern of BC 290, `readL0ID`=0.
- **Wrap:** `latency`=200, L0 at BC 260 (`wptr` wrapped) → returns word from BC 60 with its BCID.
- **Back-to-back:** 8 consecutive L0 with `readReady`=0 → `fifoFull`=1, L0IDs 0..7 in order, no overflow.
- **Overflow:** 9th L0 with `readReady`=0 → `overflow`=1, `dropCount`=1. Next accepted event gets L0ID 9.
- **Full plus pop:** FIFO full with pop and push in the same cycle → no drop; count stays 8.
- **Reset mid-stream:** assert `hrdrst` with 3 events queued and one in flight → all outputs return to reset values immediately. The first L0 after release is tagged L0ID 0.
